// File: rtl/jtframe_frac_cen_mch.sv
// Multi-channel fractional clock-enable generator: per-channel n/m accumulator feeding a binary cen/cenb divider.
// Latency: 1 clk from the edge where the accumulator crosses m to tick/cen/cenb on the outputs.
// No backpressure: outputs are free-running 1-cycle pulses; halt freezes a channel in place, sync re-phases all.
module jtframe_frac_cen_mch #(
    parameter int CH  = 2,
    parameter int W   = 4,
    parameter int WC  = 10,
    parameter bit RLD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*WC-1:0]  n_in,
    input  logic [CH*WC-1:0]  m_in,
    input  logic [CH-1:0]     ld,
    input  logic [CH-1:0]     halt,
    input  logic              sync,
    output logic [CH*W-1:0]   cen,
    output logic [CH*W-1:0]   cenb,
    output logic [CH-1:0]     tick
);

    // Mask selecting cnt[k:0]
    function automatic logic [W-1:0] low_mask(input int k);
        logic [W-1:0] msk;
        msk = '0;
        for (int j = 0; j < W; j++) begin
            if (j <= k) msk[j] = 1'b1;
        end
        return msk;
    endfunction

    // Value 2**k within the divider width: the half-period point of cen[k]
    function automatic logic [W-1:0] half_val(input int k);
        logic [W-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    genvar c;
    generate
        for (c = 0; c < CH; c++) begin : g_ch
            logic [WC-1:0] n_q, m_q, n_d, m_d;
            logic [WC-1:0] n_new, m_new;
            logic [WC:0]   acc_q, acc_d, sum;
            logic [W-1:0]  cnt_q, cnt_d;
            logic          tick_q, tick_d;
            logic [W-1:0]  cen_q, cen_d, cenb_q, cenb_d;

            assign n_new = n_in[c*WC +: WC];
            assign m_new = m_in[c*WC +: WC];
            assign sum   = acc_q + {1'b0, n_q};

            // Next-state: priority sync > ld > halt > normal accumulation
            always_comb begin
                n_d    = n_q;
                m_d    = m_q;
                acc_d  = acc_q;
                cnt_d  = cnt_q;
                tick_d = 1'b0;
                cen_d  = '0;
                cenb_d = '0;
                if (sync) begin
                    // Global re-phase; a coincident load still lands
                    if (ld[c]) begin
                        n_d = n_new;
                        m_d = m_new;
                    end
                    acc_d = '0;
                    cnt_d = '0;
                end else if (ld[c]) begin
                    n_d = n_new;
                    m_d = m_new;
                    if (RLD) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end else if (acc_q >= {1'b0, m_new}) begin
                        // Keep the invariant acc < m under the new ratio
                        acc_d = '0;
                    end
                end else if (halt[c]) begin
                    // Frozen: acc/cnt held, outputs forced low by the defaults
                    acc_d = acc_q;
                end else if (m_q == '0) begin
                    acc_d = '0;
                end else if (n_q >= m_q) begin
                    // Ratio at or above 1: saturate to a tick every cycle
                    tick_d = 1'b1;
                    acc_d  = '0;
                end else if (sum >= {1'b0, m_q}) begin
                    tick_d = 1'b1;
                    acc_d  = sum - {1'b0, m_q};
                end else begin
                    acc_d = sum;
                end

                // Divider chain: decode the count before it advances
                if (tick_d) begin
                    cnt_d = cnt_q + 1'b1;
                    for (int k = 0; k < W; k++) begin
                        cen_d[k]  = ((cnt_q & low_mask(k)) == '0);
                        cenb_d[k] = ((cnt_q & low_mask(k)) == half_val(k));
                    end
                end
            end

            // State and registered outputs; reset restores the 1/2 ratio
            always_ff @(posedge clk) begin
                if (rst) begin
                    n_q    <= WC'(1);
                    m_q    <= WC'(2);
                    acc_q  <= '0;
                    cnt_q  <= '0;
                    tick_q <= 1'b0;
                    cen_q  <= '0;
                    cenb_q <= '0;
                end else begin
                    n_q    <= n_d;
                    m_q    <= m_d;
                    acc_q  <= acc_d;
                    cnt_q  <= cnt_d;
                    tick_q <= tick_d;
                    cen_q  <= cen_d;
                    cenb_q <= cenb_d;
                end
            end

            assign tick[c]          = tick_q;
            assign cen[c*W +: W]    = cen_q;
            assign cenb[c*W +: W]   = cenb_q;
        end
    endgenerate

endmodule

// File: tb/tb_jtframe_frac_cen_mch.sv
module tb_jtframe_frac_cen_mch;
    localparam int CH = 2;
    localparam int W  = 4;
    localparam int WC = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH*WC-1:0]  n_in, m_in;
    logic [CH-1:0]     ld, halt;
    logic              sync;
    logic [CH*W-1:0]   cen, cenb;
    logic [CH-1:0]     tick;

    int checks = 0;
    int failures = 0;

    jtframe_frac_cen_mch #(.CH(CH), .W(W), .WC(WC), .RLD(1'b1)) dut (
        .clk(clk), .rst(rst), .n_in(n_in), .m_in(m_in), .ld(ld),
        .halt(halt), .sync(sync), .cen(cen), .cenb(cenb), .tick(tick)
    );

    always #5 clk = ~clk;

    // Reference model: per channel, active cycles since last re-phase and ticks emitted.
    // Tick at active step s iff floor(s*n/m) exceeds floor((s-1)*n/m); cen/cenb decoded from tick index.
    int          mn [CH];
    int          mm [CH];
    longint      steps [CH];
    longint      nt [CH];
    logic        e_tick [CH];
    logic [W-1:0] e_cen [CH];
    logic [W-1:0] e_cenb [CH];

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            e_tick[c] = 1'b0;
            e_cen[c]  = '0;
            e_cenb[c] = '0;
            if (rst) begin
                mn[c] = 1; mm[c] = 2; steps[c] = 0; nt[c] = 0;
            end else if (sync || ld[c]) begin
                if (ld[c]) begin
                    mn[c] = int'(n_in[c*WC +: WC]);
                    mm[c] = int'(m_in[c*WC +: WC]);
                end
                steps[c] = 0; nt[c] = 0;
            end else if (!halt[c]) begin
                logic t;
                steps[c]++;
                if (mm[c] == 0) t = 1'b0;
                else if (mn[c] >= mm[c]) t = 1'b1;
                else t = ((steps[c] * mn[c]) / mm[c]) != (((steps[c] - 1) * mn[c]) / mm[c]);
                if (t) begin
                    e_tick[c] = 1'b1;
                    for (int k = 0; k < W; k++) begin
                        longint p = longint'(2) << k;
                        e_cen[c][k]  = (nt[c] % p) == 0;
                        e_cenb[c][k] = (nt[c] % p) == (p / 2);
                    end
                    nt[c]++;
                end
            end
        end
    endtask

    // One clock: advance, sample 1 time unit later, compare every channel against the model
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (tick[c] !== e_tick[c] || cen[c*W +: W] !== e_cen[c] || cenb[c*W +: W] !== e_cenb[c]) begin
                failures++;
                $display("FAIL model ch%0d t=%0t got tick=%b cen=%b cenb=%b exp tick=%b cen=%b cenb=%b",
                         c, $time, tick[c], cen[c*W +: W], cenb[c*W +: W], e_tick[c], e_cen[c], e_cenb[c]);
            end
        end
    endtask

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Count ch0 outputs over a window of cycles
    task automatic run_window(input int cycles, output int nt0, output int nc0, output int nb0, output int nc3);
        nt0 = 0; nc0 = 0; nb0 = 0; nc3 = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            nt0 += int'(tick[0]);
            nc0 += int'(cen[0]);
            nb0 += int'(cenb[0]);
            nc3 += int'(cen[3]);
        end
    endtask

    typedef struct {
        int n;
        int m;
        int cycles;
        int exp_ticks;
        int exp_cen0;
        int exp_cenb0;
        int exp_cen3;
    } vec_t;

    initial begin
        vec_t vt [8];
        int a, b, d, e;
        int gap0, gap1;
        logic seen;

        vt[0] = '{1,    2, 64, 32, 16, 16, 2};
        vt[1] = '{3,    8, 64, 24, 12, 12, 2};
        vt[2] = '{0,    0, 100, 0,  0,  0, 0};
        vt[3] = '{5,    5, 64, 64, 32, 32, 4};
        vt[4] = '{7,    3, 64, 64, 32, 32, 4};
        vt[5] = '{2,    3, 30, 20, 10, 10, 2};
        vt[6] = '{0,    7, 50, 0,  0,  0, 0};
        vt[7] = '{1, 1023, 64, 0,  0,  0, 0};

        rst = 1'b1; n_in = '0; m_in = '0; ld = '0; halt = '0; sync = 1'b0;
        step();
        step();
        check("reset_outputs", longint'({tick, cen, cenb}), 0);
        rst = 1'b0;

        // Default 1/2 ratio straight out of reset
        run_window(64, a, b, d, e);
        check("default_ticks", a, 32);
        check("default_cen0", b, 16);
        check("default_cenb0", d, 16);
        check("default_cen3", e, 2);

        // Directed ratios loaded on ch0
        for (int i = 0; i < 8; i++) begin
            n_in[WC-1:0] = WC'(vt[i].n);
            m_in[WC-1:0] = WC'(vt[i].m);
            ld[0] = 1'b1;
            step();
            ld[0] = 1'b0;
            check($sformatf("ld_gap_v%0d", i), longint'({tick[0], cen[W-1:0], cenb[W-1:0]}), 0);
            run_window(vt[i].cycles, a, b, d, e);
            check($sformatf("ticks_v%0d", i), a, vt[i].exp_ticks);
            check($sformatf("cen0_v%0d", i), b, vt[i].exp_cen0);
            check($sformatf("cenb0_v%0d", i), d, vt[i].exp_cenb0);
            check($sformatf("cen3_v%0d", i), e, vt[i].exp_cen3);
        end

        // Halt ch1 for 13 cycles mid-period
        n_in = {WC'(3), WC'(1)};
        m_in = {WC'(8), WC'(2)};
        ld = 2'b11;
        step();
        ld = '0;
        for (int i = 0; i < 5; i++) step();
        halt[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step();
            seen |= tick[1] | (|cen[2*W-1:W]) | (|cenb[2*W-1:W]);
        end
        halt[1] = 1'b0;
        check("halt_ch1_quiet", longint'(seen), 0);
        for (int i = 0; i < 40; i++) step();

        // Sync with different ratios: both cen[W-1] fire together, then diverge
        n_in = {WC'(3), WC'(1)};
        m_in = {WC'(4), WC'(2)};
        ld = 2'b11;
        step();
        ld = '0;
        for (int i = 0; i < 7; i++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_clear", longint'({tick, cen, cenb}), 0);
        step();
        check("sync_first", longint'({cen[2*W-1], cen[W-1]}), 0);
        step();
        check("sync_aligned", longint'({cen[2*W-1], cen[W-1]}), 3);
        gap0 = -1; gap1 = -1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (cen[W-1] && gap0 < 0) gap0 = i;
            if (cen[2*W-1] && gap1 < 0) gap1 = i;
        end
        check("sync_period_ch0", gap0, 32);
        check("sync_period_ch1", gap1, 21);

        // Reset mid-run with a coincident load
        n_in = {WC'(9), WC'(9)};
        m_in = {WC'(10), WC'(10)};
        ld = 2'b11;
        rst = 1'b1;
        step();
        check("rst_mid_outputs", longint'({tick, cen, cenb}), 0);
        rst = 1'b0;
        ld = '0;
        run_window(64, a, b, d, e);
        check("rst_mid_ratio_ticks", a, 32);
        check("rst_mid_ratio_cen3", e, 2);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++) begin
                ld[c]   = ($urandom_range(0, 29) == 0);
                halt[c] = ($urandom_range(0, 7) == 0);
                n_in[c*WC +: WC] = ($urandom_range(0, 9) == 0) ? WC'($urandom) : WC'($urandom_range(0, 14));
                m_in[c*WC +: WC] = ($urandom_range(0, 9) == 0) ? WC'($urandom) : WC'($urandom_range(0, 12));
            end
            sync = ($urandom_range(0, 59) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; ld = '0; halt = '0; sync = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
